// File: rtl/clahe_pkg.sv
// Shared CLAHE geometry: default resolution/grid and width helpers.
// Used by the tile locator, histogram and interpolation blocks.
package clahe_pkg;

    localparam int DEF_WIDTH      = 1280;
    localparam int DEF_HEIGHT     = 720;
    localparam int DEF_TILE_H_NUM = 8;
    localparam int DEF_TILE_V_NUM = 8;
    localparam int DEF_DATA_W     = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Counter width, never below one bit so degenerate grids still have a port.
    function automatic int cwidth(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int tile_size(input int extent, input int tiles);
        return extent / tiles;
    endfunction

    // The last tile absorbs the remainder, so it is the widest one.
    function automatic int tile_span(input int extent, input int tiles);
        return extent / tiles + extent % tiles;
    endfunction

endpackage

// File: rtl/clahe_axis_tracker.sv
// Purpose: incremental position / tile-local / tile-index counter for one image axis.
// Latency: cnt/loc/tile are combinational views of the registered state (0 while clr).
// Backpressure: none; advances on every step, wrap forces the axis back to zero.
module clahe_axis_tracker
    import clahe_pkg::*;
#(
    parameter int EXTENT = DEF_WIDTH,
    parameter int TILES  = DEF_TILE_H_NUM
) (
    input  logic                                      pclk,
    input  logic                                      rst_n,
    input  logic                                      clr,
    input  logic                                      step,
    input  logic                                      wrap,
    output logic [cwidth(EXTENT)-1:0]                 cnt,
    output logic [cwidth(tile_span(EXTENT, TILES))-1:0] loc,
    output logic [cwidth(TILES)-1:0]                  tile,
    output logic                                      last
);

    localparam int CW = cwidth(EXTENT);
    localparam int LW = cwidth(tile_span(EXTENT, TILES));
    localparam int TW = cwidth(TILES);
    localparam logic [CW-1:0] CNT_END  = CW'(EXTENT - 1);
    localparam logic [LW-1:0] LOC_END  = LW'(tile_size(EXTENT, TILES) - 1);
    localparam logic [TW-1:0] TILE_END = TW'(TILES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] loc_q, loc_d;
    logic [TW-1:0] tile_q, tile_d;

    assign cnt  = clr ? '0 : cnt_q;
    assign loc  = clr ? '0 : loc_q;
    assign tile = clr ? '0 : tile_q;
    assign last = (cnt == CNT_END);

    always_comb begin
        cnt_d  = cnt;
        loc_d  = loc;
        tile_d = tile;
        if (wrap || (step && last)) begin
            cnt_d  = '0;
            loc_d  = '0;
            tile_d = '0;
        end else if (step) begin
            cnt_d = cnt + 1'b1;
            // The last tile never rolls over; its local offset runs to the axis end.
            if ((loc == LOC_END) && (tile != TILE_END)) begin
                loc_d  = '0;
                tile_d = tile + 1'b1;
            end else begin
                loc_d = loc + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            loc_q  <= '0;
            tile_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            loc_q  <= loc_d;
            tile_q <= tile_d;
        end
    end

endmodule

// File: rtl/clahe_tile_locator.sv
// Purpose: tracks pixel position per frame, emits tile index, tile-local coords and boundary flags.
// Latency: every output registered, 1 cycle after the in_href/in_data sample.
// Backpressure: none; one pixel accepted per in_href cycle, errors flagged on malformed lines.
module clahe_tile_locator
    import clahe_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int TILE_H_NUM = DEF_TILE_H_NUM,
    parameter int TILE_V_NUM = DEF_TILE_V_NUM,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                                              pclk,
    input  logic                                              rst_n,
    input  logic                                              in_href,
    input  logic                                              in_vsync,
    input  logic [DATA_W-1:0]                                 in_data,
    output logic                                              out_valid,
    output logic [DATA_W-1:0]                                 out_data,
    output logic [cwidth(WIDTH)-1:0]                          x_cnt,
    output logic [cwidth(HEIGHT)-1:0]                         y_cnt,
    output logic [cwidth(TILE_H_NUM)-1:0]                     tile_x,
    output logic [cwidth(TILE_V_NUM)-1:0]                     tile_y,
    output logic [cwidth(TILE_H_NUM)+cwidth(TILE_V_NUM)-1:0]  tile_idx,
    output logic [cwidth(tile_span(WIDTH, TILE_H_NUM))-1:0]   local_x,
    output logic [cwidth(tile_span(HEIGHT, TILE_V_NUM))-1:0]  local_y,
    output logic                                              tile_first,
    output logic                                              tile_last_x,
    output logic                                              line_end,
    output logic                                              frame_start,
    output logic                                              frame_end,
    output logic                                              err_line
);

    localparam int TILE_W = tile_size(WIDTH, TILE_H_NUM);
    localparam int TILE_H = tile_size(HEIGHT, TILE_V_NUM);
    localparam int XW  = cwidth(WIDTH);
    localparam int YW  = cwidth(HEIGHT);
    localparam int TXW = cwidth(TILE_H_NUM);
    localparam int TYW = cwidth(TILE_V_NUM);
    localparam int IW  = TXW + TYW;
    localparam int LXW = cwidth(tile_span(WIDTH, TILE_H_NUM));
    localparam int LYW = cwidth(tile_span(HEIGHT, TILE_V_NUM));
    localparam logic [LXW-1:0] LX_END = LXW'(TILE_W - 1);
    localparam logic [TXW-1:0] TX_END = TXW'(TILE_H_NUM - 1);

    logic           vsync_d;
    logic           last_pix_d;
    logic [XW-1:0]  x_c;
    logic [LXW-1:0] x_l;
    logic [TXW-1:0] x_t;
    logic           x_last;
    logic [YW-1:0]  y_c;
    logic [LYW-1:0] y_l;
    logic [TYW-1:0] y_t;
    logic           y_last;

    logic vs_rise, clr, px, short_line, line_done, overlong;

    assign vs_rise    = in_vsync & ~vsync_d;
    assign clr        = vs_rise | ~in_vsync;
    assign px         = in_href & in_vsync;
    // x_c is already forced to 0 by clr, so this only fires inside an active frame.
    assign short_line = ~in_href & (x_c != '0);
    assign line_done  = (px & x_last) | short_line;
    assign overlong   = px & last_pix_d & ~vs_rise;

    clahe_axis_tracker #(.EXTENT(WIDTH), .TILES(TILE_H_NUM)) u_x (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (px),
        .wrap  (short_line),
        .cnt   (x_c),
        .loc   (x_l),
        .tile  (x_t),
        .last  (x_last)
    );

    clahe_axis_tracker #(.EXTENT(HEIGHT), .TILES(TILE_V_NUM)) u_y (
        .pclk  (pclk),
        .rst_n (rst_n),
        .clr   (clr),
        .step  (line_done),
        .wrap  (1'b0),
        .cnt   (y_c),
        .loc   (y_l),
        .tile  (y_t),
        .last  (y_last)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d     <= 1'b0;
            last_pix_d  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            tile_idx    <= '0;
            local_x     <= '0;
            local_y     <= '0;
            tile_first  <= 1'b0;
            tile_last_x <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            err_line    <= 1'b0;
        end else begin
            vsync_d     <= in_vsync;
            last_pix_d  <= px & x_last;
            out_valid   <= px;
            out_data    <= in_data;
            x_cnt       <= x_c;
            y_cnt       <= y_c;
            tile_x      <= x_t;
            tile_y      <= y_t;
            tile_idx    <= IW'(y_t) * IW'(TILE_H_NUM) + IW'(x_t);
            local_x     <= x_l;
            local_y     <= y_l;
            tile_first  <= px & (x_l == '0);
            tile_last_x <= px & (x_last | ((x_l == LX_END) && (x_t != TX_END)));
            line_end    <= px & x_last;
            frame_start <= vs_rise;
            frame_end   <= px & x_last & y_last;
            err_line    <= vs_rise ? 1'b0 : (err_line | short_line | overlong);
        end
    end

endmodule
